// File: rtl/bp_pkg.sv
// bp_pkg: counter encodings, allocation/reset constants and PC index/tag extraction for the branch predictor
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bp_ctr_e;
  localparam bp_ctr_e ALLOC_CTR = WT;
  localparam bp_ctr_e RESET_CTR = WNT;
  function automatic logic [31:0] pc_idx(input logic [127:0] pc, input int idx_w);
    return 32'((pc >> 2) & ((128'(1) << idx_w) - 128'(1)));
  endfunction
  function automatic logic [31:0] pc_tag(input logic [127:0] pc, input int idx_w, input int tag_w);
    return 32'((pc >> (idx_w + 2)) & ((128'(1) << tag_w) - 128'(1)));
  endfunction
endpackage

// File: rtl/bp_sat_ctr2.sv
// bp_sat_ctr2: 2-bit saturating up/down counter next-state logic
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  bp_ctr_e ctr,
  input  logic    up,
  output bp_ctr_e nxt
);
  // step toward the outcome, pinning at the strong states
  always_comb nxt = up ? (ctr == ST ? ST : bp_ctr_e'(ctr + 2'd1)) : (ctr == SNT ? SNT : bp_ctr_e'(ctr - 2'd1));
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: 2-bit counter history table with tagged targets; GSHARE_EN adds global-history indexing
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ENTRIES = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
`ifdef GSHARE_EN
  output logic [IDX_W-1:0] pred_ghr,
  input  logic [IDX_W-1:0] upd_ghr,
`endif
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    bp_ctr_e          ctr;
    logic [XLEN-1:0]  target;
  } entry_t;
  entry_t tbl [ENTRIES];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  entry_t l_e, u_e;
  logic u_hit;
  bp_ctr_e u_nxt;
  assign l_tag = TAG_W'(pc_tag(128'(if_pc), IDX_W, TAG_W));
  assign u_tag = TAG_W'(pc_tag(128'(upd_pc), IDX_W, TAG_W));
`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr;
  assign pred_ghr = ghr;
  assign l_idx = IDX_W'(pc_idx(128'(if_pc), IDX_W)) ^ ghr;
  assign u_idx = IDX_W'(pc_idx(128'(upd_pc), IDX_W)) ^ upd_ghr;
  // shift in each resolved outcome; on a mispredict rebuild from the snapshot the branch was fetched with
  always_ff @(posedge clk)
    if (reset) ghr <= '0;
    else if (upd_valid) ghr <= mispredict ? {upd_ghr[IDX_W-2:0], upd_taken} : {ghr[IDX_W-2:0], upd_taken};
`else
  assign l_idx = IDX_W'(pc_idx(128'(if_pc), IDX_W));
  assign u_idx = IDX_W'(pc_idx(128'(upd_pc), IDX_W));
`endif
  assign l_e = tbl[l_idx];
  assign u_e = tbl[u_idx];
  assign u_hit = u_e.valid && u_e.tag == u_tag;
  bp_sat_ctr2 u_ctr (.ctr(u_e.ctr), .up(upd_taken), .nxt(u_nxt));
  // lookup reads registered state only, so a same-cycle update is seen next cycle
  always_comb begin
    pred_hit = l_e.valid && l_e.tag == l_tag;
    pred_taken = pred_hit && l_e.ctr[1];
    pred_target = pred_taken ? l_e.target : if_pc + XLEN'(4);
    mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_taken && upd_pred_target != upd_target));
  end
  // train on hits, allocate on taken misses, ignore not-taken misses
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '{valid: 1'b0, tag: '0, ctr: RESET_CTR, target: '0};
    end else if (upd_valid) begin
      if (u_hit) begin
        tbl[u_idx].ctr <= u_nxt;
        if (upd_taken) tbl[u_idx].target <= upd_target;
      end else if (upd_taken) begin
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, ctr: ALLOC_CTR, target: upd_target};
      end
    end
  // count mispredicts, holding at all-ones
  always_ff @(posedge clk)
    if (reset) mispredict_cnt <= '0;
    else if (mispredict && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + 1'b1;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed and random checks of the predictor against a table-level reference model
module tb_branch_predictor_bht;
  localparam int XLEN = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [XLEN-1:0] if_pc = '0;
  logic pred_hit, pred_taken, mispredict;
  logic [XLEN-1:0] pred_target;
  logic upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [XLEN-1:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic [CNT_W-1:0] mispredict_cnt;
  int total = 0;
  int bad = 0;
  bit m_v [ENTRIES];
  int m_tag [ENTRIES];
  int m_ctr [ENTRIES];
  logic [XLEN-1:0] m_tgt [ENTRIES];
  int m_cnt;
  logic [XLEN-1:0] pool [6];
  branch_predictor_bht #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
  );
  always #5 clk = ~clk;
  function automatic int m_idx(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction
  function automatic int m_tagof(input logic [XLEN-1:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction
  function automatic bit m_hit(input logic [XLEN-1:0] pc);
    return m_v[m_idx(pc)] && m_tag[m_idx(pc)] == m_tagof(pc);
  endfunction
  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 0;
      m_tag[i] = 0;
      m_ctr[i] = 1;
      m_tgt[i] = '0;
    end
    m_cnt = 0;
  endtask
  task automatic do_reset(input logic v);
    reset = 1'b1;
    upd_valid = v;
    upd_pc = 32'h100;
    upd_taken = 1'b1;
    upd_target = 32'h80;
    upd_pred_taken = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    upd_valid = 1'b0;
    m_reset();
  endtask
  task automatic do_cycle(input string nm, input logic v, input logic [XLEN-1:0] upc, input logic t,
                          input logic [XLEN-1:0] tgt, input logic pt, input logic [XLEN-1:0] ptgt,
                          input logic [XLEN-1:0] lpc);
    bit eh, et, em;
    int i;
    upd_valid = v;
    upd_pc = upc;
    upd_taken = t;
    upd_target = tgt;
    upd_pred_taken = pt;
    upd_pred_target = ptgt;
    if_pc = lpc;
    #2;
    eh = m_hit(lpc);
    et = eh && m_ctr[m_idx(lpc)] >= 2;
    em = v && (pt != t || (t && pt && ptgt != tgt));
    chk({nm, ".hit"}, XLEN'(pred_hit), XLEN'(eh));
    chk({nm, ".taken"}, XLEN'(pred_taken), XLEN'(et));
    chk({nm, ".target"}, pred_target, et ? m_tgt[m_idx(lpc)] : lpc + 32'd4);
    chk({nm, ".mispredict"}, XLEN'(mispredict), XLEN'(em));
    chk({nm, ".cnt"}, XLEN'(mispredict_cnt), XLEN'(m_cnt));
    @(posedge clk);
    if (v) begin
      i = m_idx(upc);
      if (m_hit(upc)) begin
        m_ctr[i] = t ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
        if (t) m_tgt[i] = tgt;
      end else if (t) begin
        m_v[i] = 1;
        m_tag[i] = m_tagof(upc);
        m_ctr[i] = 2;
        m_tgt[i] = tgt;
      end
    end
    if (em && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    #1;
  endtask
  initial begin
    logic [XLEN-1:0] rpc, rtgt;
    logic rv, rt;
    m_reset();
    @(posedge clk);
    #1;
    do_reset(1'b0);
    if_pc = 32'h100;
    #1;
    chk("rst.hit", XLEN'(pred_hit), 32'd0);
    chk("rst.taken", XLEN'(pred_taken), 32'd0);
    chk("rst.target", pred_target, 32'h104);
    chk("rst.cnt", XLEN'(mispredict_cnt), 32'd0);
    do_cycle("alloc", 1, 32'h100, 1, 32'h80, 0, 32'h0, 32'h100);
    do_cycle("after_alloc", 0, 'x, 'x, 'x, 'x, 'x, 32'h100);
    chk("alloc.direct_target", pred_target, 32'h80);
    do_cycle("nt1", 1, 32'h100, 0, 32'h0, 1, 32'h80, 32'h100);
    do_cycle("nt2", 1, 32'h100, 0, 32'h0, 0, 32'h0, 32'h100);
    chk("nt.direct_taken", XLEN'(pred_taken), 32'd0);
    do_cycle("nt3", 1, 32'h100, 0, 32'h0, 0, 32'h0, 32'h100);
    do_cycle("nt4", 1, 32'h100, 0, 32'h0, 0, 32'h0, 32'h100);
    do_cycle("up1", 1, 32'h100, 1, 32'h90, 0, 32'h0, 32'h100);
    do_cycle("up2", 1, 32'h100, 1, 32'h94, 1, 32'h90, 32'h100);
    do_cycle("tgt_chg", 1, 32'h100, 1, 32'h98, 1, 32'h94, 32'h100);
    do_cycle("tgt_chk", 0, 'x, 'x, 'x, 'x, 'x, 32'h100);
    do_cycle("alias", 1, 32'h100 + 4 * ENTRIES, 1, 32'h200, 0, 32'h0, 32'h100);
    do_cycle("alias_old", 0, 'x, 'x, 'x, 'x, 'x, 32'h100);
    chk("alias.direct_miss", XLEN'(pred_hit), 32'd0);
    do_cycle("alias_new", 0, 'x, 'x, 'x, 'x, 'x, 32'h100 + 4 * ENTRIES);
    do_cycle("wrap", 0, 'x, 'x, 'x, 'x, 'x, 32'hFFFF_FFFC);
    chk("wrap.direct", pred_target, 32'h0);
    for (int k = 0; k < (1 << CNT_W) + 3; k++)
      do_cycle("sat", 1, 32'h300, 0, 32'h0, 1, 32'h0, 32'h300);
    chk("sat.direct", XLEN'(mispredict_cnt), 32'd15);
    pool[0] = 32'h100;
    pool[1] = 32'h140;
    pool[2] = 32'h180;
    pool[3] = 32'h104;
    pool[4] = 32'h108;
    pool[5] = 32'h1C4;
    for (int k = 0; k < 400; k++) begin
      rpc = $urandom_range(0, 7) < 6 ? pool[$urandom_range(0, 5)] : ($urandom & 32'hFFFF_FFFC);
      rtgt = $urandom_range(0, 1) ? 32'h200 : ($urandom & 32'hFFFF_FFFC);
      rv = $urandom_range(0, 3) != 0;
      rt = 1'($urandom_range(0, 1));
      if (rv)
        do_cycle("rnd", 1, rpc, rt, rtgt, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? rtgt : 32'h200, pool[$urandom_range(0, 5)]);
      else
        do_cycle("rnd_idle", 0, 'x, 'x, 'x, 'x, 'x, pool[$urandom_range(0, 5)]);
      if (k == 200) begin
        do_reset(1'b1);
        if_pc = 32'h100;
        #1;
        chk("midrst.hit", XLEN'(pred_hit), 32'd0);
        chk("midrst.cnt", XLEN'(mispredict_cnt), 32'd0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
